// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART frame constants, state encoding and vote helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   DATA_W     = 8;
    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial line input and received-byte outputs of uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if
    import uart_pkg::*;
();
    logic              uart_rx;
    logic [DATA_W-1:0] rx_data;
    logic              rx_vld;
    logic              rx_err;
    logic              rx_busy;

    modport master (
        input  uart_rx,
        output rx_data,
        output rx_vld,
        output rx_err,
        output rx_busy
    );

    modport slave (
        output uart_rx,
        input  rx_data,
        input  rx_vld,
        input  rx_err,
        input  rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Purpose  : Two-flop synchronizer, history flop, arming flag, falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic       r_armed;
    logic [1:0] r_fill;

    // r_fill marks when r_s2 holds a real line sample rather than its reset
    // value, so a line held low through reset never arms the detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_s3    <= 1'b1;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_fill <= {r_fill[0], 1'b1};
            if (r_s2 && r_fill[1]) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_sync = r_s2;
    assign o_fall = r_armed & r_s3 & ~r_s2;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver; optional 2-of-3 vote via UART_RX_MAJORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);
    localparam int               CNT_W    = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] C_MID    = CNT_W'(BIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(BIT_CYCLES - 1);

    uart_state_e       r_state;
    uart_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_bit_idx;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_vld;
    logic              r_rx_err;

    logic w_line;
    logic w_fall;
    logic w_sample_pt;
    logic w_bit;
    logic w_shift;
    logic w_vld_nxt;
    logic w_err_nxt;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.uart_rx),
        .o_sync  (w_line),
        .o_fall  (w_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] C_MID_LO = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] C_MID_HI = CNT_W'(BIT_CYCLES / 2 + 1);

    logic r_v_lo;
    logic r_v_mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_lo  <= 1'b1;
            r_v_mid <= 1'b1;
        end else begin
            if (r_cnt == C_MID_LO) r_v_lo  <= w_line;
            if (r_cnt == C_MID)    r_v_mid <= w_line;
        end
    end

    // Third vote is the live line, so the decision lands one cycle after MID.
    assign w_sample_pt = (r_cnt == C_MID_HI);
    assign w_bit       = maj3(r_v_lo, r_v_mid, w_line);
`else
    assign w_sample_pt = (r_cnt == C_MID);
    assign w_bit       = w_line;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_vld_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) w_state_nxt = START;
            end
            START: begin
                if (w_sample_pt) w_state_nxt = (w_bit == START_BIT) ? DATA : IDLE;
            end
            DATA: begin
                if (w_sample_pt) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 4'(DATA_W)) w_state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so the next start edge is caught on time.
                if (w_sample_pt) begin
                    w_state_nxt = IDLE;
                    if (w_bit == STOP_BIT) w_vld_nxt = 1'b1;
                    else                   w_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_rx_data <= '0;
            r_rx_vld  <= 1'b0;
            r_rx_err  <= 1'b0;
        end else begin
            if (r_state == IDLE || w_state_nxt == IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == IDLE) begin
                r_bit_idx <= '0;
            end else if (r_cnt == C_LAST) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            if (w_shift) begin
                r_shreg <= {w_bit, r_shreg[DATA_W-1:1]};
            end

            r_rx_vld <= w_vld_nxt;
            r_rx_err <= w_err_nxt;
            if (w_vld_nxt) begin
                r_rx_data <= r_shreg;
            end
        end
    end

    assign bus.rx_data = r_rx_data;
    assign bus.rx_vld  = r_rx_vld;
    assign bus.rx_err  = r_rx_err;
    assign bus.rx_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx at BIT_CYCLES = 10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    localparam int BC  = 10;
    localparam int MID = BC / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Line edge seen at posedge A -> rx_vld visible after posedge A + LAT.
    localparam int LAT = 3 + 9 * BC + MID + MAJ;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(.BIT_CYCLES(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    int         n_vld      = 0;
    int         n_err      = 0;
    int         n_busy     = 0;
    int         n_both     = 0;
    int         n_vld_busy = 0;
    int         rise_cyc   = 0;
    logic       busy_q     = 1'b0;
    logic [3:0] v_wp       = 4'd0;
    logic [7:0] vdata [0:15];
    int         vcyc  [0:15];

    always @(negedge clk) begin
        busy_q <= bus.rx_busy;
        if (bus.rx_busy === 1'b1) n_busy <= n_busy + 1;
        if (bus.rx_busy === 1'b1 && busy_q !== 1'b1) rise_cyc <= cyc;
        if (bus.rx_err === 1'b1) n_err <= n_err + 1;
        if (bus.rx_vld === 1'b1 && bus.rx_err === 1'b1) n_both <= n_both + 1;
        if (bus.rx_vld === 1'b1) begin
            n_vld       <= n_vld + 1;
            vdata[v_wp] <= bus.rx_data;
            vcyc[v_wp]  <= cyc;
            v_wp        <= v_wp + 4'd1;
            if (bus.rx_busy !== 1'b0) n_vld_busy <= n_vld_busy + 1;
        end
    end

    task automatic send_bit(input logic v, input int flip_k, output int first_edge);
        for (int k = 1; k <= BC; k++) begin
            @(negedge clk);
            if (k == 1) first_edge = cyc + 1;
            bus.uart_rx = (k == flip_k) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip,
                              output int start_edge);
        int fk;
        int dummy;
        fk = flip ? (MID + 2) : 0;
        send_bit(1'b0, fk, start_edge);
        for (int i = 0; i < 8; i++) send_bit(d[i], fk, dummy);
        send_bit(stop, fk, dummy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.uart_rx = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int b0, v0, e0;
        bus.uart_rx = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.rx_data); end
        checks++; if (bus.rx_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", bus.rx_vld); end
        checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.rx_err); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.rx_busy); end
        rst_n = 1'b1;
        b0 = n_busy; v0 = n_vld; e0 = n_err;
        repeat (50) @(negedge clk);
        checks++; if (n_busy - b0 != 0) begin errors++; $display("FAIL low_line_busy got %0d exp 0", n_busy - b0); end
        checks++; if (n_vld - v0 != 0) begin errors++; $display("FAIL low_line_vld got %0d exp 0", n_vld - v0); end
        checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL low_line_err got %0d exp 0", n_err - e0); end
    endtask

    task automatic test_arm();
        int v0, s;
        v0 = n_vld;
        idle(5);
        send_frame(8'h3C, 1'b1, 1'b0, s);
        idle(5);
        checks++; if (n_vld - v0 != 1) begin errors++; $display("FAIL arm_vld_count got %0d exp 1", n_vld - v0); end
        checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL arm_data got %h exp 3c", bus.rx_data); end
    endtask

    task automatic test_frame();
        int v0, e0, vb0, s;
        logic [3:0] i0;
        bus.uart_rx = 1'b0;
        do_reset();
        idle(5);
        v0 = n_vld; e0 = n_err; vb0 = n_vld_busy; i0 = v_wp;
        send_frame(8'hA5, 1'b1, 1'b0, s);
        idle(5);
        checks++; if (n_vld - v0 != 1) begin errors++; $display("FAIL frame_vld_count got %0d exp 1", n_vld - v0); end
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL frame_data got %h exp a5", bus.rx_data); end
        checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL frame_err got %0d exp 0", n_err - e0); end
        checks++; if (vcyc[i0] - s != LAT) begin errors++; $display("FAIL frame_latency got %0d exp %0d", vcyc[i0] - s, LAT); end
        checks++; if (rise_cyc - s != 2) begin errors++; $display("FAIL busy_rise got %0d exp 2", rise_cyc - s); end
        checks++; if (n_vld_busy - vb0 != 0) begin errors++; $display("FAIL busy_at_vld got %0d exp 0", n_vld_busy - vb0); end
    endtask

    task automatic test_framing_err();
        int v0, e0, s;
        v0 = n_vld; e0 = n_err;
        send_frame(8'hFF, 1'b0, 1'b0, s);
        idle(5);
        checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL ferr_err_cycles got %0d exp 1", n_err - e0); end
        checks++; if (n_vld - v0 != 0) begin errors++; $display("FAIL ferr_vld got %0d exp 0", n_vld - v0); end
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept got %h exp a5", bus.rx_data); end
    endtask

    task automatic test_glitch();
        int v0, e0, b0;
        v0 = n_vld; e0 = n_err; b0 = n_busy;
        repeat (3) begin
            @(negedge clk);
            bus.uart_rx = 1'b0;
        end
        idle(30);
        checks++; if (n_busy - b0 != MID + 1 + MAJ) begin errors++; $display("FAIL glitch_busy got %0d exp %0d", n_busy - b0, MID + 1 + MAJ); end
        checks++; if (n_vld - v0 != 0 || n_err - e0 != 0) begin errors++; $display("FAIL glitch_pulses got vld %0d err %0d exp 0 0", n_vld - v0, n_err - e0); end
    endtask

    task automatic test_back_to_back();
        int v0, s;
        logic [3:0] i0;
        v0 = n_vld; i0 = v_wp;
        send_frame(8'h00, 1'b1, 1'b0, s);
        send_frame(8'h55, 1'b1, 1'b0, s);
        send_frame(8'h80, 1'b1, 1'b0, s);
        idle(5);
        checks++; if (n_vld - v0 != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n_vld - v0); end
        checks++; if (vdata[i0] !== 8'h00) begin errors++; $display("FAIL b2b_data0 got %h exp 00", vdata[i0]); end
        checks++; if (vdata[i0 + 4'd1] !== 8'h55) begin errors++; $display("FAIL b2b_data1 got %h exp 55", vdata[i0 + 4'd1]); end
        checks++; if (vdata[i0 + 4'd2] !== 8'h80) begin errors++; $display("FAIL b2b_data2 got %h exp 80", vdata[i0 + 4'd2]); end
        checks++; if (vcyc[i0 + 4'd1] - vcyc[i0] != 10 * BC) begin errors++; $display("FAIL b2b_gap01 got %0d exp %0d", vcyc[i0 + 4'd1] - vcyc[i0], 10 * BC); end
        checks++; if (vcyc[i0 + 4'd2] - vcyc[i0 + 4'd1] != 10 * BC) begin errors++; $display("FAIL b2b_gap12 got %0d exp %0d", vcyc[i0 + 4'd2] - vcyc[i0 + 4'd1], 10 * BC); end
    endtask

    task automatic test_reset_mid();
        int v0, e0, s;
        logic [7:0] d;
        d = 8'h5A;
        v0 = n_vld; e0 = n_err;
        send_bit(1'b0, 0, s);
        for (int i = 0; i < 4; i++) send_bit(d[i], 0, s);
        repeat (3) begin
            @(negedge clk);
            bus.uart_rx = d[4];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.rx_busy); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", bus.rx_data); end
        repeat (3) @(negedge clk);
        bus.uart_rx = 1'b1;
        rst_n = 1'b1;
        idle(5);
        send_frame(8'h81, 1'b1, 1'b0, s);
        idle(5);
        checks++; if (n_vld - v0 != 1) begin errors++; $display("FAIL midrst_vld_count got %0d exp 1", n_vld - v0); end
        checks++; if (bus.rx_data !== 8'h81) begin errors++; $display("FAIL midrst_data_after got %h exp 81", bus.rx_data); end
        checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL midrst_err got %0d exp 0", n_err - e0); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        int v0, e0, s;
        v0 = n_vld; e0 = n_err;
        send_frame(8'h81, 1'b1, 1'b1, s);
        idle(5);
        checks++; if (n_vld - v0 != 1) begin errors++; $display("FAIL maj_vld_count got %0d exp 1", n_vld - v0); end
        checks++; if (bus.rx_data !== 8'h81) begin errors++; $display("FAIL maj_data got %h exp 81", bus.rx_data); end
        checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL maj_err got %0d exp 0", n_err - e0); end
    endtask
`endif

    initial begin
        bus.uart_rx = 1'b0;
        test_reset();
        test_arm();
        test_frame();
        test_framing_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        checks++; if (n_both != 0) begin errors++; $display("FAIL vld_err_overlap got %0d exp 0", n_both); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
